// File: rtl/host_loader_pkg.sv
// Shared types for the host loader: command op-codes, FSM states and the
// per-state control outputs the FSM registers alongside its state.
package host_loader_pkg;

   localparam int CMD_W = 16;

   typedef enum logic [1:0] {
      OP_LOAD_I = 2'd0,
      OP_LOAD_D = 2'd1,
      OP_RUN    = 2'd2,
      OP_DUMP   = 2'd3
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_I = 3'd1,
      S_LOAD_D = 3'd2,
      S_RUN    = 3'd3,
      S_DUMP   = 3'd4,
      S_DRAIN  = 3'd5
   } state_t;

   typedef struct packed {
      logic cmd_ready;
      logic din_ready;
      logic mem_sel;
      logic core_rst_n;
      logic busy;
   } ctl_t;

   // Control outputs that hold for the whole time the FSM sits in a state.
   function automatic ctl_t ctl_of(input state_t s);
      case (s)
         S_IDLE:            ctl_of = '{cmd_ready: 1'b1, din_ready: 1'b0, mem_sel: 1'b1, core_rst_n: 1'b0, busy: 1'b0};
         S_LOAD_I, S_LOAD_D: ctl_of = '{cmd_ready: 1'b0, din_ready: 1'b1, mem_sel: 1'b1, core_rst_n: 1'b0, busy: 1'b1};
         S_RUN:             ctl_of = '{cmd_ready: 1'b0, din_ready: 1'b0, mem_sel: 1'b0, core_rst_n: 1'b1, busy: 1'b1};
         default:           ctl_of = '{cmd_ready: 1'b0, din_ready: 1'b0, mem_sel: 1'b1, core_rst_n: 1'b0, busy: 1'b1};
      endcase
   endfunction

   function automatic state_t op_state(input op_t op);
      case (op)
         OP_LOAD_I: op_state = S_LOAD_I;
         OP_LOAD_D: op_state = S_LOAD_D;
         OP_RUN:    op_state = S_RUN;
         default:   op_state = S_DUMP;
      endcase
   endfunction

endpackage

// File: rtl/host_loader_if.sv
// Host-side bus of the loader: command channel, write stream and readback stream.
interface host_loader_if
   import host_loader_pkg::*;
#(
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   op_t               cmd_op;
   logic [CMD_W-1:0]  cmd_addr;
   logic [CMD_W-1:0]  cmd_len;
   logic              din_valid;
   logic              din_ready;
   logic [DATA_W-1:0] din_data;
   logic              dout_valid;
   logic              dout_ready;
   logic [DATA_W-1:0] dout_data;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_len, din_valid, din_data, dout_ready,
      input  cmd_ready, din_ready, dout_valid, dout_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_len, din_valid, din_data, dout_ready,
      output cmd_ready, din_ready, dout_valid, dout_data
   );
endinterface

// File: rtl/host_loader_fifo.sv
// Two-entry readback FIFO; the head word stays put until the host accepts it.
module host_loader_fifo #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_count
);
   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_pop;

   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign w_pop   = o_valid & i_ready;

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   // The producer never pushes into a full FIFO, so no overflow guard here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/host_loader.sv
// Host loader: fills instruction/data memories, releases the core, dumps data memory.
// Build option: define HOST_LOADER_TIMEOUT_EN to bound RUN by the command's cycle budget.
module host_loader
   import host_loader_pkg::*;
#(
   parameter int IADDR_W = 8,
   parameter int INST_W  = 32,
   parameter int DADDR_W = 8,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   host_loader_if.slave       bus,
   output logic               o_imem_we,
   output logic [IADDR_W-1:0] o_imem_addr,
   output logic [INST_W-1:0]  o_imem_wdata,
   output logic               o_dmem_we,
   output logic [DADDR_W-1:0] o_dmem_addr,
   output logic [DATA_W-1:0]  o_dmem_wdata,
   input  logic [DATA_W-1:0]  i_dmem_rdata,
   output logic               o_mem_sel,
   output logic               o_core_rst_n,
   input  logic               i_core_done,
   output logic               o_busy,
   output logic               o_timeout
);
   state_t             r_state;
   ctl_t               r_ctl;
   logic [CMD_W-1:0]   r_addr;
   logic [CMD_W-1:0]   r_cnt;
   logic               r_timeout;
   logic               r_imem_we;
   logic [IADDR_W-1:0] r_imem_addr;
   logic [INST_W-1:0]  r_imem_wdata;
   logic               r_dmem_we;
   logic [DADDR_W-1:0] r_dmem_addr;
   logic [DATA_W-1:0]  r_dmem_wdata;
   logic               r_rd_issue;
   logic               r_rd_valid;
   logic               w_cmd_hs;
   logic               w_din_hs;
   logic               w_issue;
   logic [2:0]         w_pending;
   state_t             w_op_state;
   logic               w_fifo_valid;
   logic [DATA_W-1:0]  w_fifo_data;
   logic [1:0]         w_fifo_count;

   assign w_cmd_hs   = bus.cmd_valid & r_ctl.cmd_ready;
   assign w_din_hs   = bus.din_valid & r_ctl.din_ready;
   assign w_op_state = op_state(bus.cmd_op);
   // Reads issue only while every in-flight word is guaranteed a FIFO slot.
   assign w_pending  = {1'b0, w_fifo_count} + {2'b00, r_rd_issue} + {2'b00, r_rd_valid};
   assign w_issue    = (r_state == S_DUMP) && (w_pending < 3'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ctl        <= ctl_of(S_IDLE);
         r_addr       <= '0;
         r_cnt        <= '0;
         r_timeout    <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_rd_issue   <= 1'b0;
         r_rd_valid   <= 1'b0;
      end else begin
         r_imem_we  <= 1'b0;
         r_dmem_we  <= 1'b0;
         r_rd_issue <= w_issue;
         r_rd_valid <= r_rd_issue;
         case (r_state)
            S_IDLE: begin
               if (w_cmd_hs) begin
                  r_addr <= bus.cmd_addr;
                  r_cnt  <= bus.cmd_len;
                  if (bus.cmd_op == OP_RUN) r_timeout <= 1'b0;
                  if (bus.cmd_len != '0) begin
                     r_state <= w_op_state;
                     r_ctl   <= ctl_of(w_op_state);
                  end
               end
            end
            S_LOAD_I, S_LOAD_D: begin
               if (w_din_hs) begin
                  if (r_state == S_LOAD_I) begin
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= r_addr[IADDR_W-1:0];
                     r_imem_wdata <= bus.din_data[INST_W-1:0];
                  end else begin
                     r_dmem_we    <= 1'b1;
                     r_dmem_addr  <= r_addr[DADDR_W-1:0];
                     r_dmem_wdata <= bus.din_data;
                  end
                  r_addr <= r_addr + 16'd1;
                  r_cnt  <= r_cnt - 16'd1;
                  if (r_cnt == 16'd1) begin
                     r_state <= S_IDLE;
                     r_ctl   <= ctl_of(S_IDLE);
                  end
               end
            end
            S_RUN: begin
               if (i_core_done) begin
                  r_state <= S_IDLE;
                  r_ctl   <= ctl_of(S_IDLE);
               end
`ifdef HOST_LOADER_TIMEOUT_EN
               else if (r_cnt == 16'd1) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_IDLE;
                  r_ctl     <= ctl_of(S_IDLE);
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
`endif
            end
            S_DUMP: begin
               if (w_issue) begin
                  r_dmem_addr <= r_addr[DADDR_W-1:0];
                  r_addr      <= r_addr + 16'd1;
                  r_cnt       <= r_cnt - 16'd1;
                  if (r_cnt == 16'd1) begin
                     r_state <= S_DRAIN;
                     r_ctl   <= ctl_of(S_DRAIN);
                  end
               end
            end
            S_DRAIN: begin
               if (w_fifo_count == 2'd0 && !r_rd_issue && !r_rd_valid) begin
                  r_state <= S_IDLE;
                  r_ctl   <= ctl_of(S_IDLE);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ctl   <= ctl_of(S_IDLE);
            end
         endcase
      end
   end

   host_loader_fifo #(.W(DATA_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_rd_valid),
      .i_data  (i_dmem_rdata),
      .i_ready (bus.dout_ready),
      .o_valid (w_fifo_valid),
      .o_data  (w_fifo_data),
      .o_count (w_fifo_count)
   );

   assign bus.cmd_ready  = r_ctl.cmd_ready;
   assign bus.din_ready  = r_ctl.din_ready;
   assign bus.dout_valid = w_fifo_valid;
   assign bus.dout_data  = w_fifo_data;
   assign o_imem_we      = r_imem_we;
   assign o_imem_addr    = r_imem_addr;
   assign o_imem_wdata   = r_imem_wdata;
   assign o_dmem_we      = r_dmem_we;
   assign o_dmem_addr    = r_dmem_addr;
   assign o_dmem_wdata   = r_dmem_wdata;
   assign o_mem_sel      = r_ctl.mem_sel;
   assign o_core_rst_n   = r_ctl.core_rst_n;
   assign o_busy         = r_ctl.busy;
   assign o_timeout      = r_timeout;
endmodule

// File: tb/tb_host_loader.sv
// Self-checking bench for host_loader: directed and randomized loads, dumps, runs,
// zero-length commands and mid-operation resets against a behavioural memory model.
module tb_host_loader;
   import host_loader_pkg::*;

   localparam int IADDR_W = 8;
   localparam int INST_W  = 32;
   localparam int DADDR_W = 8;
   localparam int DATA_W  = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   host_loader_if #(.DATA_W(DATA_W)) bus ();

   logic               imem_we;
   logic [IADDR_W-1:0] imem_addr;
   logic [INST_W-1:0]  imem_wdata;
   logic               dmem_we;
   logic [DADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0]  dmem_wdata;
   logic [DATA_W-1:0]  dmem_rdata;
   logic               mem_sel;
   logic               core_rst_n;
   logic               core_done = 1'b0;
   logic               busy;
   logic               timeout;

   host_loader #(
      .IADDR_W(IADDR_W), .INST_W(INST_W), .DADDR_W(DADDR_W), .DATA_W(DATA_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .o_imem_we    (imem_we),
      .o_imem_addr  (imem_addr),
      .o_imem_wdata (imem_wdata),
      .o_dmem_we    (dmem_we),
      .o_dmem_addr  (dmem_addr),
      .o_dmem_wdata (dmem_wdata),
      .i_dmem_rdata (dmem_rdata),
      .o_mem_sel    (mem_sel),
      .o_core_rst_n (core_rst_n),
      .i_core_done  (core_done),
      .o_busy       (busy),
      .o_timeout    (timeout)
   );

   // Data memory seen by the DUT: synchronous read, write only while the loader owns it.
   logic [DATA_W-1:0] dmem_env [256];
   always @(posedge clk) begin
      if (mem_sel && dmem_we) dmem_env[dmem_addr] <= dmem_wdata;
      dmem_rdata <= dmem_env[dmem_addr];
   end

   // Reference contents of data memory, written from the commands the bench issues.
   logic [DATA_W-1:0] dmem_ref [256];

   int n_iwe = 0;
   int n_dwe = 0;
   always @(posedge clk) begin
      if (imem_we === 1'b1) n_iwe++;
      if (dmem_we === 1'b1) n_dwe++;
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rst(input string tag);
      chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
      chk({tag, "_din_ready"}, bus.din_ready, 0);
      chk({tag, "_dout_valid"}, bus.dout_valid, 0);
      chk({tag, "_imem_we"}, imem_we, 0);
      chk({tag, "_dmem_we"}, dmem_we, 0);
      chk({tag, "_imem_addr"}, imem_addr, 0);
      chk({tag, "_dmem_addr"}, dmem_addr, 0);
      chk({tag, "_mem_sel"}, mem_sel, 1);
      chk({tag, "_core_rst_n"}, core_rst_n, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_timeout"}, timeout, 0);
   endtask

   task automatic send_cmd(input op_t op, input int addr, input int len);
      bit hs;
      int k;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = 16'(addr);
      bus.cmd_len   = 16'(len);
      k = 0;
      do begin
         hs = bus.cmd_ready;
         tick();
         k++;
      end while (!hs && k < 50);
      bus.cmd_valid = 1'b0;
      chk("cmd_accept", hs, 1);
   endtask

   task automatic load_op(input op_t op, input int base, input logic [31:0] words[$]);
      int ni0, nd0, n, k, exp_addr;
      bit hs;
      n   = words.size();
      ni0 = n_iwe;
      nd0 = n_dwe;
      send_cmd(op, base, n);
      chk("load_busy", busy, 1);
      chk("load_mem_sel", mem_sel, 1);
      for (int i = 0; i < n; i++) begin
         bus.din_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         bus.din_valid = 1'b1;
         bus.din_data  = words[i];
         k = 0;
         do begin
            hs = bus.din_ready;
            tick();
            k++;
         end while (!hs && k < 50);
         bus.din_valid = 1'b0;
         chk("din_accept", hs, 1);
         exp_addr = (base + i) % 256;
         if (op == OP_LOAD_I) begin
            chk("imem_we", imem_we, 1);
            chk("imem_addr", imem_addr, exp_addr);
            chk("imem_wdata", imem_wdata, words[i]);
         end else begin
            chk("dmem_we", dmem_we, 1);
            chk("dmem_addr", dmem_addr, exp_addr);
            chk("dmem_wdata", dmem_wdata, words[i]);
            dmem_ref[exp_addr] = words[i];
         end
      end
      chk("load_idle", bus.cmd_ready, 1);
      chk("load_din_off", bus.din_ready, 0);
      tick();
      chk("imem_we_pulses", n_iwe - ni0, (op == OP_LOAD_I) ? n : 0);
      chk("dmem_we_pulses", n_dwe - nd0, (op == OP_LOAD_D) ? n : 0);
   endtask

   task automatic dump_op(input int base, input int n, input bit toggle);
      int got, k;
      bit v, r;
      logic [31:0] d;
      send_cmd(OP_DUMP, base, n);
      got = 0;
      k = 0;
      while (got < n && k < 400) begin
         v = bus.dout_valid;
         d = bus.dout_data;
         r = toggle ? ((k % 2) == 0) : ($urandom_range(0, 2) != 0);
         bus.dout_ready = r;
         if (v) chk("dout_data", d, dmem_ref[(base + got) % 256]);
         tick();
         k++;
         if (v && r) got++;
      end
      bus.dout_ready = 1'b0;
      chk("dump_count", got, n);
      k = 0;
      while (!bus.cmd_ready && k < 10) begin
         tick();
         k++;
      end
      chk("dump_idle", bus.cmd_ready, 1);
      chk("dump_no_extra", bus.dout_valid, 0);
   endtask

   // done_at = 0 means the core never reports done.
   task automatic run_op(input int len, input int done_at);
      int highs, exp_highs;
      bit exp_to;
`ifdef HOST_LOADER_TIMEOUT_EN
      if (done_at == 0 || done_at > len) begin
         exp_highs = len;
         exp_to    = 1'b1;
      end else begin
         exp_highs = done_at;
         exp_to    = 1'b0;
      end
`else
      exp_highs = done_at;
      exp_to    = 1'b0;
`endif
      send_cmd(OP_RUN, 0, len);
      chk("run_timeout_cleared", timeout, 0);
      chk("run_mem_sel", mem_sel, 0);
      chk("run_busy", busy, 1);
      highs = 0;
      while (core_rst_n && highs < 300) begin
         highs++;
         core_done = (highs == done_at);
         tick();
      end
      core_done = 1'b0;
      chk("run_cycles", highs, exp_highs);
      chk("run_timeout", timeout, exp_to);
      chk("run_idle", bus.cmd_ready, 1);
      chk("run_mem_sel_back", mem_sel, 1);
   endtask

   task automatic zero_len(input op_t op);
      int ni0, nd0;
      ni0 = n_iwe;
      nd0 = n_dwe;
      send_cmd(op, int'($urandom_range(0, 65535)), 0);
      chk("zl_cmd_ready", bus.cmd_ready, 1);
      chk("zl_busy", busy, 0);
      repeat (3) begin
         chk("zl_core_rst_n", core_rst_n, 0);
         chk("zl_dout_valid", bus.dout_valid, 0);
         chk("zl_mem_sel", mem_sel, 1);
         tick();
      end
      chk("zl_imem_we", n_iwe - ni0, 0);
      chk("zl_dmem_we", n_dwe - nd0, 0);
   endtask

   initial begin
      logic [31:0] q[$];
      int base, len;

      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = OP_LOAD_I;
      bus.cmd_addr   = '0;
      bus.cmd_len    = '0;
      bus.din_valid  = 1'b0;
      bus.din_data   = '0;
      bus.dout_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_rst("rst_hold");
      rst_n = 1'b1;
      tick();
      check_rst("rst_release");

      q = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      load_op(OP_LOAD_I, 16'h0310, q);

      q = {32'h1111_00FE, 32'h2222_00FF, 32'h3333_0000, 32'h4444_0001};
      load_op(OP_LOAD_D, 16'h00FE, q);

      q.delete();
      repeat (8) q.push_back($urandom);
      load_op(OP_LOAD_D, 0, q);
      dump_op(0, 5, 1'b1);
      dump_op(16'h00FE, 4, 1'b0);

      for (int it = 0; it < 6; it++) begin
         base = int'($urandom_range(0, 65535));
         len  = int'($urandom_range(1, 8));
         q.delete();
         repeat (len) q.push_back($urandom);
         load_op((it % 3 == 0) ? OP_LOAD_I : OP_LOAD_D, base, q);
         if (it % 3 != 0) dump_op(base, len, 1'b0);
      end

      run_op(100, 40);
      for (int it = 0; it < 3; it++) begin
         len = int'($urandom_range(2, 60));
         run_op(len, int'($urandom_range(1, len)));
      end

`ifdef HOST_LOADER_TIMEOUT_EN
      run_op(100, 0);
      q = {32'h5555_0000};
      load_op(OP_LOAD_D, 16'h0080, q);
      chk("timeout_sticky", timeout, 1);
      run_op(20, 20);
      run_op(15, 0);
`endif

      for (int i = 0; i < 4; i++) zero_len(op_t'(i[1:0]));

      // Reset in the middle of a data load, then reload and verify the region.
      send_cmd(OP_LOAD_D, 16'h0040, 6);
      bus.din_valid = 1'b1;
      bus.din_data  = $urandom;
      tick();
      tick();
      rst_n = 1'b0;
      bus.din_valid = 1'b0;
      #1;
      check_rst("rst_mid_load");
      tick();
      rst_n = 1'b1;
      tick();
      q.delete();
      repeat (6) q.push_back($urandom);
      load_op(OP_LOAD_D, 16'h0040, q);
      dump_op(16'h0040, 6, 1'b0);

      // Reset while the readback FIFO is full and the host is stalling.
      send_cmd(OP_DUMP, 16'h0040, 6);
      repeat (5) tick();
      chk("mid_dump_valid", bus.dout_valid, 1);
      rst_n = 1'b0;
      #1;
      check_rst("rst_mid_dump");
      tick();
      rst_n = 1'b1;
      tick();
      dump_op(16'h0040, 6, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/host_loader.md
HOST_LOADER -- requirements
Module: host_loader

Interface
REQ-001 SHALL have parameter IADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have parameter INST_W, default 32, instruction word width.
REQ-003 SHALL have parameter DADDR_W, default 8, data-memory address width.
REQ-004 SHALL have parameter DATA_W, default 32, data word width; DATA_W >= INST_W.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-009 cmd_op  in  2  0=LOAD_I, 1=LOAD_D, 2=RUN, 3=DUMP.
REQ-010 cmd_addr, cmd_len  in  16/16  base address; word count (RUN: cycle budget).
REQ-011 din_valid/din_ready/din_data  in/out/in  1/1/DATA_W  host write stream.
REQ-012 dout_valid/dout_ready/dout_data  out/in/out  1/1/DATA_W  host readback stream.
REQ-013 imem_we/imem_addr/imem_wdata  out  1/IADDR_W/INST_W  instruction-memory write port.
REQ-014 dmem_we/dmem_addr/dmem_wdata/dmem_rdata  out/out/out/in  1/DADDR_W/DATA_W/DATA_W  data-memory port; dmem_rdata valid one cycle after address.
REQ-015 mem_sel  out  1  1 = loader owns both memory ports; top-level muxes on it.
REQ-016 core_rst_n  out  1  active-low reset to the core; core_done  in  1  core halted.
REQ-017 busy, timeout  out  1/1  FSM not IDLE; sticky RUN-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, LOAD_I, LOAD_D, RUN, DUMP, DRAIN.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a handshake latches op/addr/len and moves to the op's state next cycle.
REQ-020 cmd_len==0 SHALL return to IDLE the cycle after the handshake with no memory access, no core release and no output.
REQ-021 LOAD_I/LOAD_D: din_ready=1; each din handshake SHALL produce a registered write (we=1 for exactly one cycle) in the next cycle at the current address, with imem_wdata = din_data[INST_W-1:0].
REQ-022 Address SHALL increment per word, modulo 2^IADDR_W or 2^DADDR_W (wrap, no error); cmd_addr upper bits SHALL be truncated.
REQ-023 After the len-th write, the FSM SHALL return to IDLE; din_ready SHALL be 0 outside LOAD states.
REQ-024 mem_sel SHALL be 1 and core_rst_n 0 in every state except RUN.
REQ-025 RUN: core_rst_n=1, mem_sel=0; leave to IDLE the cycle after core_done=1 is sampled.
REQ-026 DUMP: read len words from addr; outputs SHALL pass through a 2-entry FIFO; a read SHALL issue only if FIFO occupancy plus in-flight reads < 2.
REQ-027 After the last read issues, go to DRAIN; DRAIN returns to IDLE when the FIFO is empty.
REQ-028 dout_data SHALL be stable while dout_valid=1 and dout_ready=0; no word lost or duplicated.

Reset
REQ-029 On reset assertion (any state, mid-operation included), immediately: state IDLE, cmd_ready=1, din_ready=0, dout_valid=0, all we=0, addresses 0, mem_sel=1, core_rst_n=0, busy=0, timeout=0, FIFO empty.
REQ-030 Timeout SHALL clear only on reset or on acceptance of a new RUN command.

Configuration
REQ-031 With HOST_LOADER_TIMEOUT_EN defined, RUN SHALL count cycles and, if core_done has not been seen after cmd_len cycles, set timeout=1 and return to IDLE; core_done in the final cycle wins (no timeout).
REQ-032 Without HOST_LOADER_TIMEOUT_EN, RUN SHALL wait for core_done indefinitely; cmd_len is ignored for RUN and timeout is tied to 0.

Structure
REQ-033 Shared package host_loader_pkg SHALL hold the op-code enum and FSM state enum.
REQ-034 The 2-entry output FIFO SHALL be sub-module host_loader_fifo.

Verification
REQ-035 LOAD_I addr=0x10 len=3, words A,B,C -> imem writes A@0x10, B@0x11, C@0x12, one per cycle after each handshake; IDLE after the third.
REQ-036 LOAD_D addr=0xFE len=4 -> writes at 0xFE, 0xFF, 0x00, 0x01 (wrap).
REQ-037 DUMP addr=0 len=5 with dout_ready toggling 1/0 -> exactly the 5 stored words in order; dout_data held while stalled.
REQ-038 RUN len=100, core_done at cycle 40 -> core_rst_n high 40 cycles, timeout=0; with macro and no core_done -> timeout=1 after 100 cycles.
REQ-039 reset asserted mid-DUMP and mid-LOAD_D -> all outputs at reset values immediately; next command executes normally.
REQ-040 Any op with len=0 -> IDLE the next cycle, no we pulse, no dout_valid, core_rst_n stays 0.
